// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline register with a one-entry skid buffer and registered in_ready.
// Bubbles always present BUBBLE_CTRL with zero data; saturating stall counter for perf.
module pipe_skid_reg #(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 16'h0000,
    parameter int                CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    logic                r_out_valid;
    logic [CTRL_W-1:0]   r_out_ctrl;
    logic [DATA_W-1:0]   r_out_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_in_ready;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_accept;
    logic                w_drain;
    logic                w_stall;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;
    assign w_stall  = r_out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= BUBBLE_CTRL;
            r_out_data  <= '0;
            r_skid_ctrl <= BUBBLE_CTRL;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= BUBBLE_CTRL;
            r_out_data  <= '0;
            r_skid_ctrl <= BUBBLE_CTRL;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_out_ctrl  <= in_ctrl;
                        r_out_data  <= in_data;
                    end
                    r_in_ready <= 1'b1;
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        r_out_ctrl <= in_ctrl;
                        r_out_data <= in_data;
                        r_in_ready <= 1'b1;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry, close the gate.
                        r_state     <= ST_SKID;
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                    end else if (w_drain) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_out_ctrl  <= BUBBLE_CTRL;
                        r_out_data  <= '0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_drain) begin
                        r_state     <= ST_FULL;
                        r_out_ctrl  <= r_skid_ctrl;
                        r_out_data  <= r_skid_data;
                        r_skid_ctrl <= BUBBLE_CTRL;
                        r_skid_data <= '0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= BUBBLE_CTRL;
                    r_out_data  <= '0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised bench for pipe_skid_reg against a two-deep FIFO reference model.
// The model tracks occupancy, ready and the stall counter from plain queue rules.
module tb_pipe_skid_reg;

    localparam int DW = 96;
    localparam int CW = 16;
    localparam int NW = 8;
    localparam logic [CW-1:0] BUB = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    pipe_skid_reg #(
        .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(NW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] mq_d[$];
    int            m_cnt = 0;

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        ev = (mq_d.size() > 0);
        ec = ev ? mq_c[0] : BUB;
        ed = ev ? mq_d[0] : '0;
        chk("out_valid", 128'(out_valid), 128'(ev));
        chk("out_ctrl", 128'(out_ctrl), 128'(ec));
        chk("out_data", 128'(out_data), 128'(ed));
        chk("in_ready", 128'(in_ready), 128'(mq_d.size() < 2));
        chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    endtask

    task automatic model_clear();
        mq_c.delete();
        mq_d.delete();
        m_cnt = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy,
                        input logic fl);
        bit acc;
        bit drn;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = v && (mq_d.size() < 2);
        drn = (mq_d.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (mq_d.size() > 0 && !ordy && m_cnt < 255) m_cnt++;
            if (drn) begin
                void'(mq_c.pop_front());
                void'(mq_d.pop_front());
            end
            if (acc) begin
                mq_c.push_back(c);
                mq_d.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_ready = 1'b0;
        #12;
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stream 1..5 at full throughput.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, CW'(16'h100 + i), DW'(i), 1'b1, 1'b0);
            chk("stream_data", 128'(out_data), 128'(i));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_bubble", 128'(out_ctrl), 128'(BUB));

        // Fill to skid: A then B with downstream stalled.
        step(1'b1, 16'h00aa, DW'(96'hA), 1'b0, 1'b0);
        step(1'b1, 16'h00bb, DW'(96'hB), 1'b0, 1'b0);
        chk("skid_ready", 128'(in_ready), 128'(0));
        step(1'b1, 16'h00cc, DW'(96'hC), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("skid_order_b", 128'(out_data), 128'(96'hB));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Saturate the stall counter, then flush it away.
        step(1'b1, 16'h0001, DW'(96'h55), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
        end
        chk("stall_sat", 128'(stall_cnt), 128'(255));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stall_flush", 128'(stall_cnt), 128'(0));

        // Flush in SKID with a simultaneous input that must be dropped.
        step(1'b1, 16'h0011, DW'(96'h11), 1'b0, 1'b0);
        step(1'b1, 16'h0022, DW'(96'h22), 1'b0, 1'b0);
        step(1'b1, 16'h00cc, DW'(96'hC), 1'b1, 1'b1);
        chk("flush_kill", 128'(out_valid), 128'(0));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_c", 128'(out_valid), 128'(0));

        // Asynchronous reset between edges while in SKID.
        step(1'b1, 16'h0033, DW'(96'h33), 1'b0, 1'b0);
        step(1'b1, 16'h0044, DW'(96'h44), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        #1;
        rst_n = 1'b1;
        step(1'b1, 16'h0055, DW'(96'h55), 1'b1, 1'b0);
        chk("post_rst_lat", 128'(out_data), 128'(96'h55));

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0),
                 CW'($urandom),
                 rnd_data(),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
